// File: rtl/merge_pe_sched_pkg.sv
// rtl/merge_pe_sched_pkg.sv - shared states, clog2 and bus-width helpers for the merge PE path
package merge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_FEED  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int psum_bus_w(input int psum_width, input int spad_width);
    return psum_width * spad_width;
  endfunction

  function automatic int tag_bus_w(input int tag_width, input int spad_width);
    return tag_width * spad_width;
  endfunction

endpackage

// File: rtl/merge_pe_sched_if.sv
// rtl/merge_pe_sched_if.sv - scheduler to merge PE handshake bundle
interface merge_pe_sched_if
  import merge_pkg::*;
#(
  parameter int PSUM_WIDTH      = 8,
  parameter int TAG_WIDTH       = 18,
  parameter int PSUM_SPAD_WIDTH = 16
) ();
  localparam int B = psum_bus_w(PSUM_WIDTH, PSUM_SPAD_WIDTH);
  localparam int T = tag_bus_w(TAG_WIDTH, PSUM_SPAD_WIDTH);

  logic                       pe_out_rd;
  logic                       pe_psum_tag_rd;
  logic [B-1:0]               pe_psum;
  logic [PSUM_SPAD_WIDTH-1:0] pe_psum_vd;
  logic [T-1:0]               pe_tag;
  logic                       pe_tag_vd;
  logic                       pe_out_vd;
  logic [B-1:0]               pe_psum_out;

  modport master (
    output pe_out_rd, pe_psum, pe_psum_vd, pe_tag, pe_tag_vd,
    input  pe_psum_tag_rd, pe_out_vd, pe_psum_out
  );

  modport slave (
    input  pe_out_rd, pe_psum, pe_psum_vd, pe_tag, pe_tag_vd,
    output pe_psum_tag_rd, pe_out_vd, pe_psum_out
  );
endinterface

// File: rtl/merge_pe_sched_rr_pick.sv
// rtl/merge_pe_sched_rr_pick.sv - combinational round-robin pick: first request at or after ptr
module merge_rr_pick
  import merge_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found     = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
    any = found;
  end
endmodule

// File: rtl/merge_pe_sched.sv
// rtl/merge_pe_sched.sv - shares one merge PE among NUM_REQ producers, round-robin, one batch in flight
module merge_pe_sched
  import merge_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int PSUM_WIDTH      = 8,
  parameter int TAG_WIDTH       = 18,
  parameter int PSUM_SPAD_WIDTH = 16,
  parameter int MAX_WAIT        = 64,
  localparam int B  = psum_bus_w(PSUM_WIDTH, PSUM_SPAD_WIDTH),
  localparam int T  = tag_bus_w(TAG_WIDTH, PSUM_SPAD_WIDTH),
  localparam int IW = clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*B-1:0] req_psum,
  input  logic [NUM_REQ*T-1:0] req_tag,
  output logic [NUM_REQ-1:0]   gnt,
  merge_pe_sched_if.master     pe,
  output logic [B-1:0]         res_psum,
  output logic [IW-1:0]        res_id,
  output logic                 res_vd,
  output logic                 busy,
  output logic                 timeout_err
);
  localparam int CW = clog2(MAX_WAIT + 1);

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]        id_q, id_d;
  logic [B-1:0]         psum_q, psum_d;
  logic [T-1:0]         tag_q, tag_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [B-1:0]         res_psum_q, res_psum_d;
  logic [IW-1:0]        res_id_q, res_id_d;
  logic                 terr_q, terr_d;

  logic [NUM_REQ-1:0]   pick_gnt;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any;
  logic [IW-1:0]        next_ptr;
  logic                 timed_out;
  logic                 feeding;

  merge_rr_pick #(.N(NUM_REQ)) u_pick (
    .req (req),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign next_ptr  = (id_q == IW'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
  assign timed_out = (cnt_q >= CW'(MAX_WAIT - 1));

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    id_d       = id_q;
    psum_d     = psum_q;
    tag_d      = tag_q;
    cnt_d      = cnt_q;
    rr_ptr_d   = rr_ptr_q;
    res_psum_d = res_psum_q;
    res_id_d   = res_id_q;
    terr_d     = terr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_d = pick_gnt;
          id_d  = pick_idx;
          for (int k = 0; k < NUM_REQ; k++) begin
            if (pick_idx == IW'(k)) begin
              psum_d = req_psum[k*B +: B];
              tag_d  = req_tag[k*T +: T];
            end
          end
          state_d = ST_START;
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_FEED;
      end
      ST_FEED, ST_WAIT: begin
        // The awaited input wins over an expiring budget in the same cycle.
        if (state_q == ST_FEED && pe.pe_psum_tag_rd) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = ST_WAIT;
        end else if (state_q == ST_WAIT && pe.pe_out_vd) begin
          res_psum_d = pe.pe_psum_out;
          res_id_d   = id_q;
          gnt_d      = '0;
          state_d    = ST_DONE;
        end else if (timed_out) begin
          terr_d   = 1'b1;
          gnt_d    = '0;
          rr_ptr_d = next_ptr;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        rr_ptr_d = next_ptr;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      id_q       <= '0;
      psum_q     <= '0;
      tag_q      <= '0;
      cnt_q      <= '0;
      rr_ptr_q   <= '0;
      res_psum_q <= '0;
      res_id_q   <= '0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      id_q       <= id_d;
      psum_q     <= psum_d;
      tag_q      <= tag_d;
      cnt_q      <= cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      res_psum_q <= res_psum_d;
      res_id_q   <= res_id_d;
      terr_q     <= terr_d;
    end
  end

  assign feeding        = (state_q == ST_FEED) || (state_q == ST_WAIT);
  assign pe.pe_out_rd   = (state_q == ST_START);
  assign pe.pe_psum     = psum_q;
  assign pe.pe_tag      = tag_q;
  assign pe.pe_psum_vd  = {PSUM_SPAD_WIDTH{feeding}};
  assign pe.pe_tag_vd   = feeding;
  assign gnt            = gnt_q;
  assign res_psum       = res_psum_q;
  assign res_id         = res_id_q;
  assign res_vd         = (state_q == ST_DONE);
  assign busy           = (state_q != ST_IDLE);
  assign timeout_err    = terr_q;
endmodule
